pwm8_decode: RTL and testbench

Recovers the 8-bit duty value from a `PWM_sig` waveform produced by the team's 8-bit PWM generator. It is the receive end of that link. The frame is `PERIOD` clocks long and starts with a rising edge. The high time is duty+1 clocks, and a constant high means duty 255. The block synchronizes the input, measures high time and frame period, and publishes a validated duty with a one-cycle strobe per frame. It also flags malformed frames and loss of signal.

---
 rtl/pwm8_decode.sv | 98 +++++++++
 tb/tb_pwm8_decode.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm8_decode.sv
// Receive end of the 8-bit PWM link: measures high time and frame period of
// PWM_sig and publishes the validated duty with a one-cycle strobe per frame.
module pwm8_decode #(
    parameter int PERIOD = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       PWM_sig,
    output logic [7:0] duty,
    output logic       vld,
    output logic       frm_err,
    output logic       lost
);
    localparam int CW = $clog2(2 * PERIOD) + 1;
    localparam logic [CW-1:0] P1 = CW'(PERIOD);
    localparam logic [CW-1:0] P2 = CW'(2 * PERIOD);
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

    state_t        state;
    logic          s1, s2, s3;
    logic          rise, fall;
    logic [CW-1:0] pcnt, pcnt_inc, hi_len, hi_m1;

    assign rise     = s2 & ~s3;
    assign fall     = ~s2 & s3;
    assign pcnt_inc = (&pcnt) ? pcnt : pcnt + ONE;
    assign hi_m1    = hi_len - ONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= PWM_sig;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pcnt    <= '0;
            hi_len  <= '0;
            duty    <= 8'h00;
            vld     <= 1'b0;
            frm_err <= 1'b0;
            lost    <= 1'b0;
        end else begin
            vld     <= 1'b0;
            frm_err <= 1'b0;
            pcnt    <= pcnt_inc;
            case (state)
                // The first rise after IDLE only opens a measurement window.
                IDLE: begin
                    if (rise) begin
                        pcnt  <= ONE;
                        state <= HIGH;
                    end else if (pcnt == P2) begin
                        lost <= 1'b1;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        hi_len <= pcnt;
                        state  <= LOW;
                    end else if (pcnt == P1) begin
                        // Constant high: synthesize a frame start every PERIOD.
                        duty <= 8'hFF;
                        vld  <= 1'b1;
                        lost <= 1'b0;
                        pcnt <= ONE;
                    end
                end
                LOW: begin
                    if (rise) begin
                        pcnt  <= ONE;
                        state <= HIGH;
                        if (pcnt == P1) begin
                            duty <= 8'(hi_m1);
                            vld  <= 1'b1;
                            lost <= 1'b0;
                        end else begin
                            frm_err <= 1'b1;
                        end
                    end else if (pcnt == P2) begin
                        lost  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pwm8_decode.sv
// Scoreboard bench for pwm8_decode: a timestamp-based frame model pushes expected
// strobes/lost events; a negedge monitor pops and compares them.
module tb_pwm8_decode;
    localparam int P = 256;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       PWM_sig = 1'b0;
    logic [7:0] duty;
    logic       vld, frm_err, lost;

    pwm8_decode #(.PERIOD(P)) dut (
        .clk(clk), .rst_n(rst_n), .PWM_sig(PWM_sig),
        .duty(duty), .vld(vld), .frm_err(frm_err), .lost(lost)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef enum int {EV_VLD, EV_ERR, EV_LOST} kind_t;
    typedef struct {
        kind_t kind;
        int    dval;
        int    cyc;
    } ev_t;

    ev_t exp_q[$];
    int  tests = 0;
    int  fails = 0;

    // Frame model in input time: last frame start, high length of current frame.
    bit m_started = 0;
    int m_st = 0;
    int m_hl = 0;
    bit m_prev = 0;

    // Outputs appear three edges after the input level is first sampled.
    function automatic void push(kind_t k, int d, int c);
        ev_t e;
        e.kind = k;
        e.dval = d;
        e.cyc  = c + 3;
        exp_q.push_back(e);
    endfunction

    function automatic void model_step(int c, bit v);
        bit r, f;
        r = v & ~m_prev;
        f = ~v & m_prev;
        if (!m_started) begin
            if (r) begin
                m_started = 1;
                m_st = c;
                m_hl = 0;
            end
        end else if (m_hl == 0) begin
            if (f) m_hl = c - m_st;
            else if (c - m_st == P) begin
                push(EV_VLD, 255, c);
                m_st = c;
            end
        end else begin
            if (r) begin
                if (c - m_st == P) push(EV_VLD, (m_hl - 1) % 256, c);
                else push(EV_ERR, 0, c);
                m_st = c;
                m_hl = 0;
            end else if (c - m_st == 2 * P) begin
                push(EV_LOST, 0, c);
                m_started = 0;
            end
        end
        m_prev = v;
    endfunction

    task automatic chk(string nm, int got, int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic check_ev(kind_t k);
        ev_t e;
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_%s at cyc %0d duty=%02h", k.name(), cyc, duty);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != k || e.cyc != cyc || (k == EV_VLD && (duty != 8'(e.dval) || lost))) begin
            fails++;
            $display("FAIL ev_%s got kind=%s cyc=%0d duty=%02h lost=%0b, want kind=%s cyc=%0d duty=%02h lost=0",
                     e.kind.name(), k.name(), cyc, duty, lost, e.kind.name(), e.cyc, 8'(e.dval));
        end
    endtask

    logic [7:0] duty_q = 8'h00;
    logic       lost_q = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (vld && frm_err) begin
                tests++;
                fails++;
                $display("FAIL strobe_overlap vld=%0b frm_err=%0b at cyc %0d, want not both", vld, frm_err, cyc);
            end
            if (vld) check_ev(EV_VLD);
            if (frm_err) check_ev(EV_ERR);
            if (lost && !lost_q) check_ev(EV_LOST);
            if (!vld && duty != duty_q) begin
                tests++;
                fails++;
                $display("FAIL duty_hold got %02h want %02h at cyc %0d", duty, duty_q, cyc);
            end
        end
        duty_q <= duty;
        lost_q <= lost;
    end

    task automatic step(bit v);
        @(negedge clk);
        PWM_sig = v;
        model_step(cyc, v);
    endtask

    task automatic hold(bit v, int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic frame(int h, int p);
        hold(1'b1, h);
        hold(1'b0, p - h);
    endtask

    task automatic check_zero(string tag);
        chk({tag, "_duty"}, int'(duty), 0);
        chk({tag, "_vld"}, int'(vld), 0);
        chk({tag, "_frm_err"}, int'(frm_err), 0);
        chk({tag, "_lost"}, int'(lost), 0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check_zero("mid_reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_started = 0;
        m_hl = 0;
        m_prev = 0;
        model_step(cyc, PWM_sig);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cyc %0d, want run complete", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int h, p;
        #1;
        check_zero("reset");
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        hold(1'b0, 2);

        repeat (4) frame(65, P);
        repeat (2) frame(1, P);
        repeat (2) frame(255, P);
        repeat (3) frame(17, P);
        repeat (3) frame(161, P);

        repeat (2) frame(33, P);
        hold(1'b1, 3 * P);
        repeat (3) frame(33, P);

        repeat (3) frame(40, 200);
        repeat (3) frame(65, P);

        hold(1'b0, 600);
        repeat (3) frame(129, P);

        for (int i = 0; i < 24; i++) begin
            h = $urandom_range(1, 255);
            p = ($urandom_range(0, 3) == 0) ? $urandom_range(h + 1, 300) : P;
            frame(h, p);
        end

        repeat (2) frame(65, P);
        hold(1'b1, 30);
        reset_pulse();
        hold(1'b1, 40);
        hold(1'b0, 150);
        repeat (3) frame(97, P);
        hold(1'b0, 20);

        chk("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
